seg7_digit_monitor: RTL
=======================

# seg7_digit_monitor

Receive-side checker for a single active-low seven-segment digit bus, such as a HEX0 display output. It filters glitches on the segment lines and decodes stable patterns back to BCD digits. It then checks that the digits step 0→9→0 in order at a programmed interval. The block sits beside a display counter in self-checking builds, or on test headers, and reports decoded value, lock status and error pulses.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a pattern (≥2)
- EXPECT_PERIOD, 50_000_000: nominal clock cycles between successive digit changes
- PERIOD_TOL, 1000: allowed ± deviation from EXPECT_PERIOD, inclusive
- CLOCK_50  in  1  sole clock, all flops on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- seg_in  in  7  segment pattern, bit6=g … bit0=a, active-low (0 = lit)
- digit  out  4  last accepted valid digit, 0–9
- digit_valid  out  1  digit holds a decoded value
- change  out  1  one-cycle pulse on every accepted pattern change
- code_error  out  1  one-cycle pulse: accepted pattern is not a digit code
- seq_error  out  1  one-cycle pulse: valid digit ≠ (previous+1) mod 10
- timing_error  out  1  one-cycle pulse: in-sequence change outside the period window
- locked  out  1  high while in LOCKED state
- period  out  26  cycles between the last two accepted changes, saturating
- err_count  out  8  total error pulses since reset, saturating at 255

## Operation
- seg_in is registered once into seg_q. cand holds the candidate pattern; stab_cnt counts how long cand has matched seg_q.
- If seg_q ≠ cand: cand←seg_q, stab_cnt←0. Otherwise stab_cnt increments and saturates at STABLE_CYCLES−1.
- An accept occurs when stab_cnt = STABLE_CYCLES−1, seg_q = cand and cand ≠ acc_pat. On accept, acc_pat←cand and change pulses. Each accept fires exactly once per distinct stable pattern.
- Decode table, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Any other pattern, including blank 1111111, is invalid.
- FSM states: EMPTY, FIRST, LOCKED. Reset enters EMPTY.
- Invalid accept, from any state: code_error pulses, digit_valid←0, digit holds, next state EMPTY.
- Valid accept from EMPTY: digit←d, digit_valid←1, next state FIRST. No sequence or timing check.
- Valid accept from FIRST or LOCKED with d ≠ prev+1 mod 10: seq_error pulses, digit←d, next state FIRST.
- Valid accept from FIRST or LOCKED with d = prev+1 mod 10: digit←d, next state LOCKED.
  - In the same cycle, timing_error pulses if period_new < EXPECT_PERIOD−PERIOD_TOL or period_new > EXPECT_PERIOD+PERIOD_TOL.
  - The wrap 9→0 counts as in-sequence.
- Period measurement:
  - since_cnt increments every cycle and saturates at 2^26−1.
  - On accept: period←since_cnt+1 (saturating), since_cnt←0.
  - The first accept after reset also loads period, but it is never checked.
- err_count adds 1 for each cycle in which any error pulse is high, even if several are high together, and saturates at 255.

## Timing
- Reset values: digit=0, digit_valid=0, change=0, code_error=0, seq_error=0, timing_error=0, locked=0, period=0, err_count=0.
- Internal reset values: acc_pat=cand=seg_q=1111111, stab_cnt=0, since_cnt=0.
- Latency: seg_in changes to a new stable value before edge E. The outputs (change pulse, digit, errors, state) update at edge E+STABLE_CYCLES+1.
- Glitches shorter than STABLE_CYCLES+1 samples produce no accept.
- A glitch that returns to acc_pat produces no accept. since_cnt keeps running.
- All outputs are registered. Error pulses coincide with the change pulse.
- Reset asserted mid-measurement discards everything. The first pattern after reset is treated as from EMPTY.

## Structure
- The package seg7_pkg holds:
  - the ten digit pattern constants and SEG_BLANK;
  - the state enum {EMPTY, FIRST, LOCKED};
  - a function next_digit(d) returning (d+1) mod 10.
- One sub-module, seg7_decode: combinational, seg[6:0] → {valid, digit[3:0]}. It mirrors the display encoder table.
- The top module holds the sync flop, stability filter, period counter, FSM and error counter.

## Test plan
All sims use STABLE_CYCLES=4, EXPECT_PERIOD=20, PERIOD_TOL=2.

- **Clean count:** drive 0,1,…,9,0 at a 20-cycle spacing.
  - First accept 6 edges after seg_in=0, giving digit=0, FIRST.
  - locked=1 from digit 1 onward.
  - No errors; period=20 on each change.
- **Glitch rejection:** while showing 3, pulse seg_in to 0000000 for 3 cycles.
  - No change pulse; digit stays 3.
  - Repeat with a 5-cycle pulse: change pulses, digit=8, seq_error=1, state FIRST, err_count=1.
- **Timing window:** steady count, then one change at 17 cycles and one at 23 cycles.
  - timing_error pulses on both; locked stays 1; err_count=2.
  - A change at 18 cycles passes.
- **Invalid code:** while locked on 5, hold 1111111 for 10 cycles.
  - code_error pulses; digit_valid=0; locked=0; digit stays 5.
  - A following 6 enters FIRST with no seq_error.
- **Reset mid-operation:** assert reset 3 cycles into stabilizing a new digit 7.
  - All outputs return to reset values.
  - After release, a held 7 is accepted from EMPTY with no errors.
- **Saturation:** hold one pattern for more than 2^26 cycles (forced counter preload), then change.
  - period=2^26−1.
  - err_count driven past 255 holds at 255.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment digit monitor.
//   - Active-low segment patterns for digits 0-9 and the blank pattern
//     (bit6=g ... bit0=a, 0 = lit).
//   - FSM state enum for the sequence checker.
//   - next_digit(): decimal successor with 9 -> 0 wrap.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int PERIOD_W = 26;

  typedef enum logic [1:0] {EMPTY, FIRST, LOCKED} state_t;

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational active-low seven-segment to BCD decoder.
//   seg   in  7  segment pattern, bit6=g ... bit0=a, active-low
//   valid out 1  pattern is one of the ten digit codes
//   digit out 4  decoded digit (0 when not valid)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    digit = 4'd0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_digit_monitor.sv
// seg7_digit_monitor: receive-side checker for an active-low 7-segment digit.
// Filters glitches, decodes stable patterns, checks 0..9 stepping and timing.
//   CLOCK_50     in   1  clock, rising edge
//   reset        in   1  asynchronous active-high reset
//   seg_in       in   7  segment pattern, bit6=g ... bit0=a, active-low
//   digit        out  4  last accepted valid digit
//   digit_valid  out  1  digit holds a decoded value
//   change       out  1  pulse on each accepted pattern change
//   code_error   out  1  pulse: accepted pattern is not a digit
//   seq_error    out  1  pulse: digit is not previous+1 mod 10
//   timing_error out  1  pulse: in-sequence change outside period window
//   locked       out  1  sequence checker in LOCKED
//   period       out 26  cycles between last two accepts, saturating
//   err_count    out  8  error-pulse cycles since reset, saturating
module seg7_digit_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int EXPECT_PERIOD = 50_000_000,
  parameter int PERIOD_TOL    = 1000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                change,
  output logic                code_error,
  output logic                seq_error,
  output logic                timing_error,
  output logic                locked,
  output logic [PERIOD_W-1:0] period,
  output logic [7:0]          err_count
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0]       STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
  // Window bounds carry one extra bit so the upper bound cannot wrap.
  localparam logic [PERIOD_W:0] P_LO =
    (EXPECT_PERIOD > PERIOD_TOL) ? (PERIOD_W+1)'(EXPECT_PERIOD - PERIOD_TOL) : '0;
  localparam logic [PERIOD_W:0] P_HI = (PERIOD_W+1)'(EXPECT_PERIOD + PERIOD_TOL);

  logic [6:0]          seg_q, cand, acc_pat;
  logic [SW-1:0]       stab_cnt;
  logic [PERIOD_W-1:0] since_cnt, period_new;
  state_t              state;
  logic                dec_valid, accept, in_seq, out_win;
  logic                code_e, seq_e, tim_e;
  logic [3:0]          dec_digit;

  seg7_decode u_dec (.seg(cand), .valid(dec_valid), .digit(dec_digit));

  // cand is already stable for STABLE_CYCLES samples and differs from the
  // last accepted pattern; acc_pat update makes this fire once per pattern.
  assign accept     = (stab_cnt == STAB_MAX) && (seg_q == cand) && (cand != acc_pat);
  assign period_new = (since_cnt == CNT_MAX) ? CNT_MAX : since_cnt + 1'b1;
  assign in_seq     = (dec_digit == next_digit(digit));
  assign out_win    = ({1'b0, period_new} < P_LO) || ({1'b0, period_new} > P_HI);

  assign code_e = accept && !dec_valid;
  assign seq_e  = accept && dec_valid && (state != EMPTY) && !in_seq;
  assign tim_e  = accept && dec_valid && (state != EMPTY) && in_seq && out_win;

  // Input sync and stability filter.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      seg_q    <= SEG_BLANK;
      cand     <= SEG_BLANK;
      acc_pat  <= SEG_BLANK;
      stab_cnt <= '0;
    end else begin
      seg_q <= seg_in;
      if (seg_q != cand) begin
        cand     <= seg_q;
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
      if (accept) acc_pat <= cand;
    end
  end

  // Interval measurement between accepts.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      since_cnt <= '0;
      period    <= '0;
    end else if (accept) begin
      since_cnt <= '0;
      period    <= period_new;
    end else if (since_cnt != CNT_MAX) begin
      since_cnt <= since_cnt + 1'b1;
    end
  end

  // Sequence FSM with registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      digit        <= 4'd0;
      digit_valid  <= 1'b0;
      change       <= 1'b0;
      code_error   <= 1'b0;
      seq_error    <= 1'b0;
      timing_error <= 1'b0;
      locked       <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      change       <= accept;
      code_error   <= code_e;
      seq_error    <= seq_e;
      timing_error <= tim_e;
      // Several simultaneous errors still count as one event.
      if ((code_e || seq_e || tim_e) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
      if (accept) begin
        if (!dec_valid) begin
          digit_valid <= 1'b0;
          state       <= EMPTY;
          locked      <= 1'b0;
        end else begin
          digit       <= dec_digit;
          digit_valid <= 1'b1;
          if ((state == EMPTY) || !in_seq) begin
            state  <= FIRST;
            locked <= 1'b0;
          end else begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
      end
    end
  end

endmodule
